wb_ctrl: RTL

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 94 +++++++++
 rtl/wb_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths, default sizing and the writeback buffer entry layout.
package wb_pkg;

    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned XLEN            = 32;
    localparam int unsigned WB_DEPTH        = 2;
    localparam int unsigned WB_STARVE_LIMIT = 3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order LSU writeback buffer. Entries can be killed in place by an
// address match; killed entries keep their slot until they reach the head.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [4:0]  push_waddr_i,
    input  logic [31:0] push_wdata_i,
    input  logic        pop_i,
    input  logic        kill_i,
    input  logic [4:0]  kill_addr_i,
    output logic        empty_o,
    output logic        full_o,
    output logic        head_valid_o,
    output logic [4:0]  head_waddr_o,
    output logic [31:0] head_wdata_o,
    output logic [31:0] pend_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_pop;

    assign empty_o      = (cnt_q == '0);
    assign full_o       = (cnt_q == FULL_CNT);
    assign do_pop       = pop_i && !empty_o;
    assign head_valid_o = !empty_o && mem_q[rd_ptr_q].valid;
    assign head_waddr_o = mem_q[rd_ptr_q].waddr;
    assign head_wdata_o = mem_q[rd_ptr_q].wdata;

    // Next buffer state: kill existing matches first so a same-cycle push survives.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill_i && mem_q[i].valid && (mem_q[i].waddr == kill_addr_i)) begin
                mem_d[i].valid = 1'b0;
            end
        end
        if (do_pop) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, waddr: push_waddr_i, wdata: push_wdata_i};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({push_i, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pending-register mask over live entries.
    always_comb begin
        pend_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem_q[i].valid) begin
                pend_o[mem_q[i].waddr] = 1'b1;
            end
        end
    end

    // Buffer storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Register-file writeback arbiter between the EX stage and the buffered
// LSU path, with a starvation guard that briefly stalls EX.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH        = WB_DEPTH,
    parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wen_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        ex_stall_o,
    output logic [31:0] pend_o,
    output logic        err_o
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic          rdy_q, rdy_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          reg_wen_q, reg_wen_d;
    logic [4:0]    reg_waddr_q, reg_waddr_d;
    logic [31:0]   reg_wdata_q, reg_wdata_d;

    logic          push, pop, ex_issue;
    logic          empty, full, head_valid;
    logic [4:0]    head_waddr;
    logic [31:0]   head_wdata;

    // Ready depends only on flops: out of reset for a cycle and not full.
    assign lsu_ready_o = rdy_q && !full;
    // x0 requests complete the handshake but are never stored.
    assign push        = lsu_valid_i && lsu_ready_o && (lsu_waddr_i != '0);

    assign reg_wen_o   = reg_wen_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign ex_stall_o  = stall_q;
    assign err_o       = err_q;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_waddr_i (lsu_waddr_i),
        .push_wdata_i (lsu_wdata_i),
        .pop_i        (pop),
        .kill_i       (ex_issue),
        .kill_addr_i  (ex_waddr_i),
        .empty_o      (empty),
        .full_o       (full),
        .head_valid_o (head_valid),
        .head_waddr_o (head_waddr),
        .head_wdata_o (head_wdata),
        .pend_o       (pend_o)
    );

    // Arbitration, starvation tracking and next register-file write.
    always_comb begin
        rdy_d       = 1'b1;
        pop         = 1'b0;
        ex_issue    = 1'b0;
        err_d       = err_q;
        stall_d     = 1'b0;
        starve_d    = starve_q;
        reg_wen_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;

        if (stall_q) begin
            pop   = !empty;
            err_d = err_q || ex_wen_i;
        end else if (ex_wen_i) begin
            // An x0 write still owns the slot but writes and kills nothing.
            ex_issue = (ex_waddr_i != '0);
        end else begin
            pop = !empty;
        end

        if (ex_issue) begin
            reg_wen_d   = 1'b1;
            reg_waddr_d = ex_waddr_i;
            reg_wdata_d = ex_wdata_i;
        end else if (pop && head_valid) begin
            reg_wen_d   = 1'b1;
            reg_waddr_d = head_waddr;
            reg_wdata_d = head_wdata;
        end

        if (pop || empty) begin
            starve_d = '0;
        end else if (ex_issue) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
            starve_q    <= '0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            rdy_q       <= rdy_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

endmodule
